// File: rtl/rom_bist_sig_ctrl.sv
// rom_bist_sig_ctrl: MBIST read controller that sweeps a ROM and folds its data into a MISR.
//   Ports:
//     BIST_CLK_ROM_IN  - BIST clock (same clock as the wrapper's BIST clock)
//     BIST_RST_ROM_IN  - asynchronous reset, active high
//     BIST_START       - a rising edge launches a run from IDLE or DONE
//     BIST_ABORT       - level; cancels a run that is in progress
//     BIST_ROM_ENABLE  - to wrapper: selects the BIST clock/address/read enable
//     BIST_ADDR_ROM_IN - to wrapper: read address
//     BIST_REN_ROM     - to wrapper: read enable
//     DATA_ROM_OUT     - from wrapper: read data, valid RD_LATENCY cycles after a read
//     BIST_BUSY        - high from SETTLE through COMPARE
//     BIST_DONE        - sticky; the run has completed
//     BIST_PASS        - sticky; final signature matched EXP_SIG (valid when BIST_DONE)
//     BIST_SIGNATURE   - current MISR value
module rom_bist_sig_ctrl #(
    parameter int ROM_ADDR   = 11,
    parameter int ROM_WORDS  = 2048,
    parameter int ROM_BITS   = 16,
    parameter int RD_LATENCY = 1,
    parameter int SETTLE_CYC = 4,
    parameter logic [ROM_BITS-1:0] MISR_POLY = 16'h1021,
    parameter logic [ROM_BITS-1:0] MISR_SEED = 16'h0000,
    parameter logic [ROM_BITS-1:0] EXP_SIG   = 16'h0000
) (
    input  logic                BIST_CLK_ROM_IN,
    input  logic                BIST_RST_ROM_IN,
    input  logic                BIST_START,
    input  logic                BIST_ABORT,
    output logic                BIST_ROM_ENABLE,
    output logic [ROM_ADDR-1:0] BIST_ADDR_ROM_IN,
    output logic                BIST_REN_ROM,
    input  logic [ROM_BITS-1:0] DATA_ROM_OUT,
    output logic                BIST_BUSY,
    output logic                BIST_DONE,
    output logic                BIST_PASS,
    output logic [ROM_BITS-1:0] BIST_SIGNATURE
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_READ, S_DRAIN, S_COMPARE, S_DONE} state_t;

    state_t                r_state;
    logic                  r_start_q;
    logic [SW-1:0]         r_settle_cnt;
    logic [ROM_ADDR-1:0]   r_addr;
    logic [RD_LATENCY-1:0] r_vld;
    logic [ROM_BITS-1:0]   r_misr;
    logic                  r_en;
    logic                  r_ren;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;

    logic                  w_launch;
    logic                  w_busy_st;
    logic                  w_cap;
    logic [RD_LATENCY-1:0] w_vld_lo;
    logic                  w_drain_end;
    logic [ROM_BITS-1:0]   w_misr_nxt;

    assign w_busy_st   = r_state inside {S_SETTLE, S_READ, S_DRAIN, S_COMPARE};
    assign w_launch    = BIST_START & ~r_start_q & ~BIST_ABORT & (r_state inside {S_IDLE, S_DONE});
    assign w_cap       = r_vld[RD_LATENCY-1];
    // Pipe shifted by one drops the tap being captured this cycle; when the rest is empty
    // the final word lands in the MISR on this edge, so COMPARE sees the finished signature.
    assign w_vld_lo    = r_vld << 1;
    assign w_drain_end = ~|w_vld_lo;
    assign w_misr_nxt  = {r_misr[ROM_BITS-2:0], 1'b0} ^ (r_misr[ROM_BITS-1] ? MISR_POLY : '0) ^ DATA_ROM_OUT;

    assign BIST_ROM_ENABLE  = r_en;
    assign BIST_ADDR_ROM_IN = r_addr;
    assign BIST_REN_ROM     = r_ren;
    assign BIST_BUSY        = r_busy;
    assign BIST_DONE        = r_done;
    assign BIST_PASS        = r_pass;
    assign BIST_SIGNATURE   = r_misr;

    always_ff @(posedge BIST_CLK_ROM_IN or posedge BIST_RST_ROM_IN) begin
        if (BIST_RST_ROM_IN) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_settle_cnt <= '0;
            r_addr       <= '0;
            r_vld        <= '0;
            r_misr       <= MISR_SEED;
            r_en         <= 1'b0;
            r_ren        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_start_q <= BIST_START;
            r_vld     <= w_vld_lo | RD_LATENCY'(r_ren);
            if (w_cap)
                r_misr <= w_misr_nxt;
            if (BIST_ABORT && w_busy_st) begin
                r_state <= S_IDLE;
                r_vld   <= '0;
                r_en    <= 1'b0;
                r_ren   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: if (w_launch) begin
                        r_state      <= S_SETTLE;
                        r_en         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_misr       <= MISR_SEED;
                        r_addr       <= '0;
                        r_settle_cnt <= '0;
                    end
                    S_SETTLE: begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                        if (r_settle_cnt == SW'(SETTLE_CYC - 1)) begin
                            r_state <= S_READ;
                            r_ren   <= 1'b1;
                        end
                    end
                    S_READ: if (r_addr == ROM_ADDR'(ROM_WORDS - 1)) begin
                        r_state <= S_DRAIN;
                        r_ren   <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ROM_ADDR'(1);
                    end
                    S_DRAIN: if (w_drain_end)
                        r_state <= S_COMPARE;
                    S_COMPARE: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (r_misr == EXP_SIG);
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
